// File: rtl/qea_host_sequencer_pkg.sv
// Shared types and helpers for the QEA host sequencer.
// Holds the job FSM encoding plus row-count and unit-amplitude helpers.
package qea_host_pkg;

   localparam int QH_DATA_WIDTH     = 32;
   localparam int QH_NUM_FRAC_BIT   = 30;
   localparam int QH_MAX_QBIT_WIDTH = 6;

   typedef enum logic [3:0] {
      S_IDLE,
      S_LOAD_CTX,
      S_INIT_STATE,
      S_START,
      S_RUN,
      S_READ_REQ,
      S_READ_WAIT,
      S_READ_OUT,
      S_DONE
   } state_e;

   // Four amplitudes per row, so a row holds two qubits' worth of states.
   function automatic logic [31:0] rows_of(input int qbit_num);
      return 32'd1 << (qbit_num - 2);
   endfunction

   function automatic logic [2*QH_DATA_WIDTH-1:0] one_amp(
      input int frac = QH_NUM_FRAC_BIT
   );
      return {QH_DATA_WIDTH'(1) << frac, QH_DATA_WIDTH'(0)};
   endfunction

endpackage

// File: rtl/qea_host_rd_pipe.sv
// State read-back pipe: read-latency valid shift and held result beat.
// The beat stays stable until the consumer accepts it.
module qea_host_rd_pipe #(
   parameter int WIDTH      = 256,
   parameter int RD_LATENCY = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_req,
   input  logic [WIDTH-1:0] i_dout,
   input  logic             i_ready,
   output logic             o_capt,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data
);

   logic [RD_LATENCY-1:0] r_vsh;
   logic                  r_valid;
   logic [WIDTH-1:0]      r_data;

   assign o_capt  = r_vsh[RD_LATENCY-1];
   assign o_valid = r_valid;
   assign o_data  = r_data;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_vsh   <= '0;
         r_valid <= 1'b0;
         r_data  <= '0;
      end else begin
         r_vsh <= (r_vsh << 1) | RD_LATENCY'(i_req);
         if (o_capt) begin
            r_data  <= i_dout;
            r_valid <= 1'b1;
         end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/qea_host_sequencer.sv
// Hardware host for the QEA: loads context, clears state to |0..0>,
// runs and times the job, then streams every state row back out.
module qea_host_sequencer
   import qea_host_pkg::*;
#(
   parameter int PE_NUM                  = 4,
   parameter int DATA_WIDTH              = QH_DATA_WIDTH,
   parameter int STATE_DATA_WIDTH        = 2*DATA_WIDTH,
   parameter int STATE_ADDR_WIDTH        = 16,
   parameter int GATE_CONTEXT_DATA_WIDTH = 2*DATA_WIDTH,
   parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
   parameter int MAX_QBIT_WIDTH          = QH_MAX_QBIT_WIDTH,
   parameter int NUM_FRAC_BIT            = QH_NUM_FRAC_BIT,
   parameter int RD_LATENCY              = 1
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 i_go,
   input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
   input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_ins_num,
   input  logic                                 i_ctx_valid,
   output logic                                 o_ctx_ready,
   input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_word,
   output logic                                 o_qea_start,
   output logic [MAX_QBIT_WIDTH-1:0]            o_qea_qbit_num,
   output logic                                 o_qea_ctx_en,
   output logic                                 o_qea_ctx_wea,
   output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_qea_ctx_addr,
   output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_qea_ctx_data,
   output logic                                 o_qea_state_ena,
   output logic                                 o_qea_state_wea,
   output logic [STATE_ADDR_WIDTH-1:0]          o_qea_state_addra,
   output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_qea_state_dina,
   input  logic                                 i_qea_complete,
   input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_qea_state_dout,
   output logic                                 o_res_valid,
   input  logic                                 i_res_ready,
   output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_res_data,
   output logic                                 o_busy,
   output logic                                 o_done,
   output logic                                 o_err,
   output logic [31:0]                          o_exec_cycles
);

   localparam int RW = STATE_ADDR_WIDTH + 1;
   localparam int GW = GATE_CONTEXT_ADDR_WIDTH;
   localparam logic [STATE_DATA_WIDTH-1:0] ONE_AMP =
      STATE_DATA_WIDTH'(one_amp(NUM_FRAC_BIT));

   state_e                       r_state, w_next;
   logic [MAX_QBIT_WIDTH-1:0]    r_qbit;
   logic [GW-1:0]                r_ins, r_beat;
   logic [RW-1:0]                r_row, w_rows;
   logic                         r_ctx_en, r_first, r_err;
   logic [GW-1:0]                r_ctx_addr;
   logic [GATE_CONTEXT_DATA_WIDTH-1:0] r_ctx_data;
   logic [31:0]                  r_exec;
   logic w_legal, w_accept, w_last_beat, w_row_last;
   logic w_capt, w_hs, w_rd_req;

   assign w_rows      = RW'(rows_of(int'(r_qbit)));
   assign w_row_last  = (r_row == w_rows - RW'(1));
   assign w_accept    = (r_state == S_LOAD_CTX) && i_ctx_valid;
   assign w_last_beat = (r_beat == r_ins - GW'(1));
   assign w_hs        = o_res_valid && i_res_ready;
   assign w_rd_req    = (r_state == S_READ_REQ);
   assign w_legal     = (int'(i_qbit_num) >= 2)
                     && (int'(i_qbit_num) <= STATE_ADDR_WIDTH + 2)
                     && (i_ins_num != '0);

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:       if (i_go && w_legal) w_next = S_LOAD_CTX;
         S_LOAD_CTX:   if (w_accept && w_last_beat) w_next = S_INIT_STATE;
         S_INIT_STATE: if (w_row_last) w_next = S_START;
         S_START:      w_next = S_RUN;
         S_RUN:        if (!r_first && i_qea_complete) w_next = S_READ_REQ;
         S_READ_REQ:   w_next = S_READ_WAIT;
         S_READ_WAIT:  if (w_capt) w_next = S_READ_OUT;
         S_READ_OUT:   if (w_hs) w_next = w_row_last ? S_DONE : S_READ_REQ;
         S_DONE:       w_next = S_IDLE;
         default:      w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_qbit     <= '0;
         r_ins      <= '0;
         r_beat     <= '0;
         r_row      <= '0;
         r_ctx_en   <= 1'b0;
         r_ctx_addr <= '0;
         r_ctx_data <= '0;
         r_exec     <= '0;
         r_first    <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_err    <= (r_state == S_IDLE) && i_go && !w_legal;
         r_ctx_en <= w_accept;
         if (w_accept) begin
            r_ctx_addr <= r_beat;
            r_ctx_data <= i_ctx_word;
            r_beat     <= r_beat + GW'(1);
         end
         unique case (r_state)
            S_IDLE: if (i_go && w_legal) begin
               r_qbit <= i_qbit_num;
               r_ins  <= i_ins_num;
               r_beat <= '0;
               r_row  <= '0;
            end
            S_INIT_STATE: r_row <= w_row_last ? '0 : r_row + RW'(1);
            S_START: begin
               r_exec  <= '0;
               r_first <= 1'b1;
            end
            // Counting includes the cycle in which complete is seen.
            S_RUN: begin
               r_first <= 1'b0;
               if (r_exec != '1) r_exec <= r_exec + 32'd1;
            end
            S_READ_OUT: if (w_hs && !w_row_last) r_row <= r_row + RW'(1);
            default: ;
         endcase
      end
   end

   always_comb begin
      o_ctx_ready       = 1'b0;
      o_qea_start       = 1'b0;
      o_qea_state_ena   = 1'b0;
      o_qea_state_wea   = 1'b0;
      o_qea_state_addra = '0;
      o_qea_state_dina  = '0;
      o_done            = 1'b0;
      o_busy            = (r_state != S_IDLE);
      unique case (r_state)
         S_LOAD_CTX: o_ctx_ready = 1'b1;
         S_INIT_STATE: begin
            o_qea_state_ena   = 1'b1;
            o_qea_state_wea   = 1'b1;
            o_qea_state_addra = r_row[STATE_ADDR_WIDTH-1:0];
            if (r_row == '0)
               o_qea_state_dina[PE_NUM*STATE_DATA_WIDTH-1 -: STATE_DATA_WIDTH]
                  = ONE_AMP;
         end
         S_START: o_qea_start = 1'b1;
         S_READ_REQ: begin
            o_qea_state_ena   = 1'b1;
            o_qea_state_addra = r_row[STATE_ADDR_WIDTH-1:0];
         end
         S_DONE: o_done = 1'b1;
         default: ;
      endcase
   end

   assign o_qea_qbit_num = r_qbit;
   assign o_qea_ctx_en   = r_ctx_en;
   assign o_qea_ctx_wea  = r_ctx_en;
   assign o_qea_ctx_addr = r_ctx_addr;
   assign o_qea_ctx_data = r_ctx_data;
   assign o_err          = r_err;
   assign o_exec_cycles  = r_exec;

   qea_host_rd_pipe #(
      .WIDTH      (PE_NUM*STATE_DATA_WIDTH),
      .RD_LATENCY (RD_LATENCY)
   ) u_rd_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_req   (w_rd_req),
      .i_dout  (i_qea_state_dout),
      .i_ready (i_res_ready),
      .o_capt  (w_capt),
      .o_valid (o_res_valid),
      .o_data  (o_res_data)
   );

endmodule

// File: tb/tb_qea_host_sequencer.sv
// Bench for qea_host_sequencer: directed jobs with random data,
// a behavioural QEA model (state RAM + complete timer) and scoreboards.
module tb_qea_host_sequencer;

   localparam int LAT = 50;
   localparam int SW  = 256;
   localparam logic [SW-1:0] ONE_ROW = {64'h40000000_00000000, 192'b0};

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            i_go = 1'b0;
   logic [5:0]      i_qbit_num = '0;
   logic [15:0]     i_ins_num = '0;
   logic            i_ctx_valid = 1'b0;
   logic            o_ctx_ready;
   logic [63:0]     i_ctx_word = '0;
   logic            o_qea_start;
   logic [5:0]      o_qea_qbit_num;
   logic            o_qea_ctx_en, o_qea_ctx_wea;
   logic [15:0]     o_qea_ctx_addr;
   logic [63:0]     o_qea_ctx_data;
   logic            o_qea_state_ena, o_qea_state_wea;
   logic [15:0]     o_qea_state_addra;
   logic [SW-1:0]   o_qea_state_dina;
   logic            i_qea_complete = 1'b0;
   logic [SW-1:0]   i_qea_state_dout = '0;
   logic            o_res_valid;
   logic            i_res_ready = 1'b0;
   logic [SW-1:0]   o_res_data;
   logic            o_busy, o_done, o_err;
   logic [31:0]     o_exec_cycles;

   int checks = 0;
   int errors = 0;
   logic [SW-1:0] mem [0:511];
   logic [63:0]   words [0:511];
   int            ctx_a[$];
   logic [63:0]   ctx_d[$];
   int            st_a[$];
   logic [SW-1:0] st_d[$];
   int starts = 0;
   int qcnt = -1;
   int cur_rows = 0;

   qea_host_sequencer dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .i_go              (i_go),
      .i_qbit_num        (i_qbit_num),
      .i_ins_num         (i_ins_num),
      .i_ctx_valid       (i_ctx_valid),
      .o_ctx_ready       (o_ctx_ready),
      .i_ctx_word        (i_ctx_word),
      .o_qea_start       (o_qea_start),
      .o_qea_qbit_num    (o_qea_qbit_num),
      .o_qea_ctx_en      (o_qea_ctx_en),
      .o_qea_ctx_wea     (o_qea_ctx_wea),
      .o_qea_ctx_addr    (o_qea_ctx_addr),
      .o_qea_ctx_data    (o_qea_ctx_data),
      .o_qea_state_ena   (o_qea_state_ena),
      .o_qea_state_wea   (o_qea_state_wea),
      .o_qea_state_addra (o_qea_state_addra),
      .o_qea_state_dina  (o_qea_state_dina),
      .i_qea_complete    (i_qea_complete),
      .i_qea_state_dout  (i_qea_state_dout),
      .o_res_valid       (o_res_valid),
      .i_res_ready       (i_res_ready),
      .o_res_data        (o_res_data),
      .o_busy            (o_busy),
      .o_done            (o_done),
      .o_err             (o_err),
      .o_exec_cycles     (o_exec_cycles)
   );

   always #5 clk = ~clk;

   // QEA model: logs RAM writes, serves reads, raises complete LAT
   // cycles after start and leaves it stale until 2 cycles into the next run.
   always @(negedge clk) begin
      if (o_qea_ctx_en && o_qea_ctx_wea) begin
         ctx_a.push_back(int'(o_qea_ctx_addr));
         ctx_d.push_back(o_qea_ctx_data);
      end
      if (o_qea_state_ena && o_qea_state_wea) begin
         mem[o_qea_state_addra[8:0]] = o_qea_state_dina;
         st_a.push_back(int'(o_qea_state_addra));
         st_d.push_back(o_qea_state_dina);
      end
      if (o_qea_state_ena && !o_qea_state_wea)
         i_qea_state_dout = mem[o_qea_state_addra[8:0]];
      if (o_qea_start) begin
         starts++;
         qcnt = 0;
      end else if (qcnt >= 0) begin
         qcnt++;
         if (qcnt == 2) i_qea_complete = 1'b0;
         if (qcnt == LAT) begin
            for (int r = 0; r < cur_rows; r++)
               mem[r] = {$urandom, $urandom, $urandom, $urandom,
                         $urandom, $urandom, $urandom, $urandom};
            i_qea_complete = 1'b1;
            qcnt = -1;
         end
      end
   end

   task automatic chk(input string tag, input logic [SW-1:0] obs,
                      input logic [SW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string t);
      chk({t, "_ctl"}, {o_busy, o_done, o_err, o_res_valid, o_qea_start,
          o_ctx_ready, o_qea_ctx_en, o_qea_ctx_wea, o_qea_state_ena,
          o_qea_state_wea}, '0);
      chk({t, "_exec"}, o_exec_cycles, '0);
      chk({t, "_res"}, o_res_data, '0);
      chk({t, "_dina"}, o_qea_state_dina, '0);
      chk({t, "_addr"}, {o_qea_ctx_addr, o_qea_state_addra, o_qea_qbit_num}, '0);
      chk({t, "_cdata"}, o_qea_ctx_data, '0);
   endtask

   task automatic bad_go(input int q, input int ins);
      int errs = 0;
      int busy = 0;
      @(posedge clk); #1;
      i_go = 1'b1; i_qbit_num = 6'(q); i_ins_num = 16'(ins);
      @(posedge clk); #1;
      i_go = 1'b0;
      repeat (4) begin
         @(negedge clk);
         errs += int'(o_err);
         busy += int'(o_busy);
      end
      chk($sformatf("err_pulses_q%0d_i%0d", q, ins), errs, 1);
      chk($sformatf("err_busy_q%0d_i%0d", q, ins), busy, 0);
   endtask

   task automatic feed(input int ins, input bit tog);
      int k = 0;
      int cyc = 0;
      bit rdy;
      while (k < ins && cyc < 5000) begin
         i_ctx_valid = tog ? (cyc % 2 == 0) : 1'b1;
         i_ctx_word  = words[k];
         @(negedge clk);
         rdy = o_ctx_ready;
         @(posedge clk);
         if (i_ctx_valid && rdy) k++;
         #1;
         cyc++;
      end
      i_ctx_valid = 1'b0;
      chk("ctx_beats", k, ins);
   endtask

   task automatic consume(input int rows, input int stall_beat,
                          input int rst_row, input bit rnd, output bit got);
      int beat = 0;
      int stall = 0;
      int cyc = 0;
      logic [SW-1:0] held = '0;
      got = 1'b0;
      i_res_ready = 1'b1;
      while (cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (o_done) begin
            got = 1'b1;
            break;
         end
         if (o_res_valid && beat == rst_row) begin
            @(posedge clk); #1;
            rst_n = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check_zero("midrst");
            @(posedge clk); #1;
            rst_n = 1'b1;
            return;
         end
         if (beat == stall_beat && stall > 0 && stall < 10)
            chk("stall_valid", o_res_valid, 1'b1);
         if (o_res_valid && !i_res_ready) begin
            if (beat == stall_beat) begin
               if (stall == 0) held = o_res_data;
               else chk("stall_data", o_res_data, held);
               stall++;
            end
         end else if (o_res_valid) begin
            chk($sformatf("beat%0d", beat), o_res_data, mem[beat]);
            beat++;
         end
         @(posedge clk); #1;
         if (beat == stall_beat && stall < 10) i_res_ready = 1'b0;
         else i_res_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      chk("beats", beat, rows);
      chk("done_seen", got, 1'b1);
   endtask

   task automatic run_job(input int q, input int ins, input bit tog,
                          input int stall_beat, input int rst_row,
                          input bit rnd);
      int rows;
      int s0;
      bit got;
      rows = 1 << (q - 2);
      cur_rows = rows;
      ctx_a.delete(); ctx_d.delete(); st_a.delete(); st_d.delete();
      s0 = starts;
      for (int i = 0; i < ins; i++) words[i] = {$urandom, $urandom};
      @(posedge clk); #1;
      i_go = 1'b1; i_qbit_num = 6'(q); i_ins_num = 16'(ins);
      @(posedge clk); #1;
      i_go = 1'b0;
      chk("busy_on", o_busy, 1'b1);
      feed(ins, tog);
      consume(rows, stall_beat, rst_row, rnd, got);
      if (rst_row < 0) begin
         chk("exec", o_exec_cycles, LAT);
         chk("qbit", o_qea_qbit_num, q);
         chk("starts", starts - s0, 1);
         chk("ctx_n", ctx_a.size(), ins);
         for (int i = 0; i < ctx_a.size() && i < ins; i++) begin
            chk($sformatf("ctx_addr%0d", i), ctx_a[i], i);
            chk($sformatf("ctx_data%0d", i), ctx_d[i], words[i]);
         end
         chk("st_n", st_a.size(), rows);
         for (int i = 0; i < st_a.size() && i < rows; i++) begin
            chk($sformatf("st_addr%0d", i), st_a[i], i);
            chk($sformatf("st_data%0d", i), st_d[i], (i == 0) ? ONE_ROW : '0);
         end
         @(negedge clk);
         chk("busy_off", o_busy, 1'b0);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      bad_go(1, 10);
      bad_go(19, 10);
      bad_go(5, 0);
      run_job(9, 461, 1'b0, 5, -1, 1'b0);
      run_job(5, 37, 1'b1, -1, -1, 1'b1);
      run_job(9, 20, 1'b0, -1, 40, 1'b0);
      run_job(3, 5, 1'b1, -1, -1, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
